seq_alu: RTL
============

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width (even, >= 4).
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), shift-amount width taken from operand_b[SHW-1:0].
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  block can accept a request.
REQ-007 SHALL have port opcode  input  3  000 ADD, 001 SUB, 010 SHL, 011 SHR, 100 MUL, 101 DIV, 11x illegal.
REQ-008 SHALL have port operand_a  input  WIDTH  first operand (unsigned).
REQ-009 SHALL have port operand_b  input  WIDTH  second operand / shift amount.
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  consumer takes the result.
REQ-012 SHALL have port result_lo  output  WIDTH  sum/difference/shifted value/product low/quotient.
REQ-013 SHALL have port result_hi  output  WIDTH  0, except MUL product high, or DIV remainder.
REQ-014 SHALL have port status  output  4  {E,N,Z,C}: error, result_lo MSB, {result_hi,result_lo}==0, carry.

Function
REQ-015 SHALL implement FSM IDLE -> EXEC -> DONE -> IDLE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-016 SHALL accept when in_valid && in_ready, registering opcode and operands; inputs are ignored at all other times.
REQ-017 SHALL, for ADD/SUB/SHL/SHR/illegal, skip EXEC: IDLE -> DONE, out_valid high the cycle after acceptance.
REQ-018 SHALL compute ADD modulo 2^WIDTH, C = carry out.
REQ-019 SHALL compute SUB as a + ~b + 1, C = 1 iff a >= b (no borrow).
REQ-020 SHALL shift logically, zero fill, by operand_b[SHW-1:0]; C = 0.
REQ-021 SHALL compute MUL by iterative shift-add, one bit per cycle, WIDTH cycles in EXEC; out_valid WIDTH+1 cycles after acceptance; C = 0.
REQ-022 SHALL compute DIV by restoring division, WIDTH cycles in EXEC, same latency as MUL; C = 0.
REQ-023 SHALL, for DIV with operand_b == 0, go IDLE -> DONE (latency 1), result_lo all-ones, result_hi = operand_a, E = 1.
REQ-024 SHALL, for illegal opcodes, produce result 0, E = 1, Z = 1, latency 1.
REQ-025 SHALL hold result and status stable in DONE until out_valid && out_ready, then return to IDLE; next acceptance is earliest the following cycle.
REQ-026 SHALL drive result_lo, result_hi and status to 0 whenever not in DONE.

Reset
REQ-027 SHALL, on rst_n low, asynchronously enter IDLE, clear all registers, giving in_ready=1 and out_valid=0 after deassertion.
REQ-028 SHALL, on reset during EXEC or DONE, discard the operation with no result delivered.

Configuration
REQ-029 SHALL include the divider only when macro SEQ_ALU_DIV_EN is defined.
REQ-030 SHALL, without SEQ_ALU_DIV_EN, treat opcode 101 as illegal per REQ-024; all other behaviour unchanged.

Structure
REQ-031 SHALL place opcode enum, FSM state enum and status bit indices in package seq_alu_pkg.
REQ-032 SHALL implement the MUL/DIV iteration datapath (partial remainder/product, counter) in sub-module seq_alu_muldiv; the top owns FSM and handshake.

Verification (WIDTH=16)
REQ-033 SHALL check ADD 0xFFFF+0x0001 -> result_lo 0x0000, C=1, Z=1, out_valid one cycle after acceptance.
REQ-034 SHALL check SUB 5-7 -> 0xFFFE, C=0, N=1; SHR 0x8000 by 15 -> 0x0001.
REQ-035 SHALL check MUL 0x1234*0x0010 -> hi 0x0001, lo 0x2340, out_valid exactly 17 cycles after acceptance, in_ready low meanwhile.
REQ-036 SHALL check DIV 100/7 -> lo 14, hi 2 (17 cycles); DIV 0x0042/0 -> lo 0xFFFF, hi 0x0042, E=1, 1 cycle.
REQ-037 SHALL check out_ready held low 5 cycles in DONE -> outputs stable, in_ready 0, new in_valid ignored.
REQ-038 SHALL check rst_n low in cycle 8 of a MUL -> out_valid 0 and in_ready 1 after release, no stale result.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU: opcode and state encodings and status bit positions.
package seq_alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_SHL = 3'b010,
        OP_SHR = 3'b011,
        OP_MUL = 3'b100,
        OP_DIV = 3'b101
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int unsigned STAT_C = 0;
    localparam int unsigned STAT_Z = 1;
    localparam int unsigned STAT_N = 2;
    localparam int unsigned STAT_E = 3;

endpackage

// File: rtl/seq_alu_muldiv.sv
// One-bit-per-cycle shift-add multiplier and restoring divider (divider only with SEQ_ALU_DIV_EN).
// A down-counter loaded with WIDTH on start. o_last flags the final iteration step.
module seq_alu_muldiv #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
`ifdef SEQ_ALU_DIV_EN
    input  logic             i_div,
`endif
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_last,
    output logic [WIDTH-1:0] o_lo,
    output logic [WIDTH-1:0] o_hi
);
    localparam int CNTW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] r_hi, r_lo, r_m;
    logic [CNTW-1:0]  r_cnt;
    logic [WIDTH:0]   w_sum, w_add;
    logic [WIDTH-1:0] w_mul_hi, w_mul_lo, w_nxt_hi, w_nxt_lo;
`ifdef SEQ_ALU_DIV_EN
    logic             r_div;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_trial, w_div_hi, w_div_lo;
    logic             w_ge;
`endif

    // Multiply: hi accumulates, lo holds the multiplier and receives product bits from the right.
    always_comb begin
        w_sum    = {1'b0, r_hi} + {1'b0, r_m};
        w_add    = r_lo[0] ? w_sum : {1'b0, r_hi};
        w_mul_hi = w_add[WIDTH:1];
        w_mul_lo = {w_add[0], r_lo[WIDTH-1:1]};
        w_nxt_hi = w_mul_hi;
        w_nxt_lo = w_mul_lo;
`ifdef SEQ_ALU_DIV_EN
        // Divide: hi is the partial remainder, lo shifts the dividend out and quotient bits in.
        w_shift  = {r_hi, r_lo[WIDTH-1]};
        w_ge     = (w_shift >= {1'b0, r_m});
        w_trial  = w_shift[WIDTH-1:0] - r_m;
        w_div_hi = w_ge ? w_trial : w_shift[WIDTH-1:0];
        w_div_lo = {r_lo[WIDTH-2:0], w_ge};
        if (r_div) begin
            w_nxt_hi = w_div_hi;
            w_nxt_lo = w_div_lo;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi  <= '0;
            r_lo  <= '0;
            r_m   <= '0;
            r_cnt <= '0;
`ifdef SEQ_ALU_DIV_EN
            r_div <= 1'b0;
`endif
        end else if (i_start) begin
            r_hi  <= '0;
            r_cnt <= CNTW'(WIDTH);
`ifdef SEQ_ALU_DIV_EN
            r_div <= i_div;
            r_lo  <= i_div ? i_a : i_b;
            r_m   <= i_div ? i_b : i_a;
`else
            r_lo  <= i_b;
            r_m   <= i_a;
`endif
        end else if (i_step && (r_cnt != '0)) begin
            r_hi  <= w_nxt_hi;
            r_lo  <= w_nxt_lo;
            r_cnt <= r_cnt - CNTW'(1);
        end
    end

    assign o_last = (r_cnt == CNTW'(1));
    assign o_lo   = r_lo;
    assign o_hi   = r_hi;

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU top: handshake FSM, single-cycle ops, and result/status muxing.
// DIV (opcode 101) is implemented only when SEQ_ALU_DIV_EN is defined; otherwise it is illegal.
//   state   | meaning
//   IDLE    | in_ready high, waiting for in_valid
//   EXEC    | MUL/DIV iterating in seq_alu_muldiv
//   DONE    | out_valid high, result held until out_ready
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic [3:0]       status
);
    state_e           r_state, w_next;
    logic [WIDTH-1:0] r_res_lo, r_res_hi;
    logic             r_err, r_carry, r_use_md;

    logic [WIDTH:0]   w_sum, w_diff;
    logic [WIDTH-1:0] w_lo, w_hi, w_md_lo, w_md_hi, w_out_lo, w_out_hi;
    logic             w_err, w_c, w_use_md, w_div, w_accept, w_md_last;
    logic [3:0]       w_status;

    assign w_accept = (r_state == ST_IDLE) && in_valid;

    always_comb begin
        w_lo     = '0;
        w_hi     = '0;
        w_err    = 1'b0;
        w_c      = 1'b0;
        w_use_md = 1'b0;
        w_div    = 1'b0;
        w_sum    = {1'b0, operand_a} + {1'b0, operand_b};
        w_diff   = {1'b0, operand_a} + {1'b0, ~operand_b} + (WIDTH+1)'(1);
        case (opcode)
            OP_ADD: {w_c, w_lo} = w_sum;
            OP_SUB: {w_c, w_lo} = w_diff;
            OP_SHL: w_lo = operand_a << operand_b[SHW-1:0];
            OP_SHR: w_lo = operand_a >> operand_b[SHW-1:0];
            OP_MUL: w_use_md = 1'b1;
`ifdef SEQ_ALU_DIV_EN
            OP_DIV: begin
                if (operand_b == '0) begin
                    w_lo  = '1;
                    w_hi  = operand_a;
                    w_err = 1'b1;
                end else begin
                    w_use_md = 1'b1;
                    w_div    = 1'b1;
                end
            end
`endif
            default: w_err = 1'b1;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (in_valid) w_next = w_use_md ? ST_EXEC : ST_DONE;
            ST_EXEC: if (w_md_last) w_next = ST_DONE;
            ST_DONE: if (out_ready) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_res_lo <= '0;
            r_res_hi <= '0;
            r_err    <= 1'b0;
            r_carry  <= 1'b0;
            r_use_md <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_res_lo <= w_lo;
                r_res_hi <= w_hi;
                r_err    <= w_err;
                r_carry  <= w_c;
                r_use_md <= w_use_md;
            end
        end
    end

    seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_accept && w_use_md),
`ifdef SEQ_ALU_DIV_EN
        .i_div   (w_div),
`endif
        .i_step  (r_state == ST_EXEC),
        .i_a     (operand_a),
        .i_b     (operand_b),
        .o_last  (w_md_last),
        .o_lo    (w_md_lo),
        .o_hi    (w_md_hi)
    );

    // The iterative unit holds its final value once its counter reaches zero, so DONE reads it directly.
    assign w_out_lo = r_use_md ? w_md_lo : r_res_lo;
    assign w_out_hi = r_use_md ? w_md_hi : r_res_hi;

    always_comb begin
        w_status = '0;
        if (r_state == ST_DONE) begin
            w_status[STAT_E] = r_err;
            w_status[STAT_N] = w_out_lo[WIDTH-1];
            w_status[STAT_Z] = ({w_out_hi, w_out_lo} == '0);
            w_status[STAT_C] = r_carry;
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign result_lo = (r_state == ST_DONE) ? w_out_lo : '0;
    assign result_hi = (r_state == ST_DONE) ? w_out_hi : '0;
    assign status    = w_status;

endmodule
